// File: rtl/dmem_pkg.sv
// Purpose: shared types and helpers for the data-memory responder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dmem_pkg;

  localparam int WORD_W = 32;
  localparam int BE_W   = 4;
  localparam int CNT_W  = 4;   // wait counter, covers LATENCY 0..15

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Word-aligned only, and every address bit above the array index must be zero.
  function automatic logic access_err(input logic [WORD_W-1:0] addr,
                                      input int unsigned       depth_log2);
    logic [WORD_W-1:0] hi;
    hi = addr >> (depth_log2 + 2);
    return (addr[1:0] != 2'b00) || (hi != '0);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Purpose: single-port 2^DEPTH_LOG2 x 32 storage with byte-enabled write.
// Latency: write and read both complete on the enabled edge; rdata holds until the next read.
// Backpressure: none, one operation per enabled edge.
// Ports: clk; en/we select read or write; idx word index; wdata/be store data and
//        byte enables; rdata registered read word.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH_LOG2 = 8
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] idx,
  input  logic [WORD_W-1:0]     wdata,
  input  logic [BE_W-1:0]       be,
  output logic [WORD_W-1:0]     rdata
);

  logic [WORD_W-1:0] mem [0:(1<<DEPTH_LOG2)-1];

  // Contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < BE_W; i++) begin
          if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
        end
      end else begin
        rdata <= mem[idx];
      end
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Purpose: MEM-stage data-memory responder, one load/store outstanding at a time.
// Latency: response pulse LATENCY+1 cycles after the accept cycle; one access per LATENCY+2 cycles.
// Backpressure: req_ready only in IDLE; stall holds the pipeline until rsp_valid.
// Ports: clk, rst (sync, active-high); req_valid/req_write/req_addr/req_wdata/req_be request in,
//        req_ready out; rsp_valid/rsp_rdata/rsp_err response out; stall to hazard logic.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_LOG2 = 8,
  parameter int LATENCY    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [WORD_W-1:0] req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  input  logic [BE_W-1:0]   req_be,
  output logic              req_ready,
  output logic              rsp_valid,
  output logic [WORD_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              stall
);

  localparam logic [CNT_W-1:0] LAT_C = CNT_W'(LATENCY);

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  enter_resp;
  logic                  accept;
  logic                  req_err;

  // Request latch (only what the response needs; address reduced to index + error)
  logic                  wr_q;
  logic                  err_q;
  logic [DEPTH_LOG2-1:0] idx_q;
  logic [WORD_W-1:0]     wdata_q;
  logic [BE_W-1:0]       be_q;

  // Fields of the access performed on the edge entering RESP
  logic                  cur_wr;
  logic                  cur_err;
  logic [DEPTH_LOG2-1:0] cur_idx;
  logic [WORD_W-1:0]     cur_wdata;
  logic [BE_W-1:0]       cur_be;

  logic                  arr_en;
  logic [WORD_W-1:0]     arr_rdata;

  logic                  rsp_valid_q;
  logic                  rsp_err_q;
  logic                  rd_ok_q;

  assign req_ready = (state_q == IDLE) & ~rst;
  assign accept    = req_valid & req_ready;
  assign req_err   = access_err(req_addr, DEPTH_LOG2);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    enter_resp = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          cnt_d = LAT_C;
          if (LATENCY == 0) begin
            state_d    = RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == 1) begin
          state_d    = RESP;
          enter_resp = 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // With LATENCY==0 the access happens on the accept edge itself, before the
  // latch holds anything, so the live request fields are used while in IDLE.
  assign cur_wr    = (state_q == IDLE) ? req_write : wr_q;
  assign cur_err   = (state_q == IDLE) ? req_err   : err_q;
  assign cur_idx   = (state_q == IDLE) ? req_addr[DEPTH_LOG2+1:2] : idx_q;
  assign cur_wdata = (state_q == IDLE) ? req_wdata : wdata_q;
  assign cur_be    = (state_q == IDLE) ? req_be    : be_q;

  // Reset on the edge that would enter RESP discards the access.
  assign arr_en = enter_resp & ~cur_err & ~rst;

  dmem_array #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_array (
    .clk  (clk),
    .en   (arr_en),
    .we   (cur_wr),
    .idx  (cur_idx),
    .wdata(cur_wdata),
    .be   (cur_be),
    .rdata(arr_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      wr_q        <= 1'b0;
      err_q       <= 1'b0;
      idx_q       <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rd_ok_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      if (accept) begin
        wr_q    <= req_write;
        err_q   <= req_err;
        idx_q   <= req_addr[DEPTH_LOG2+1:2];
        wdata_q <= req_wdata;
        be_q    <= req_be;
      end
      rsp_valid_q <= enter_resp;
      rsp_err_q   <= enter_resp & cur_err;
      rd_ok_q     <= enter_resp & ~cur_err & ~cur_wr;
    end
  end

  // rd_ok_q is only ever set for the single RESP cycle, so data is zero otherwise.
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rd_ok_q ? arr_rdata : '0;
  assign stall     = req_valid & ~rsp_valid;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

  logic        clk;
  logic        rst       [2];
  logic        req_valid [2];
  logic        req_write [2];
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic [3:0]  req_be    [2];
  logic        req_ready [2];
  logic        rsp_valid [2];
  logic [31:0] rsp_rdata [2];
  logic        rsp_err   [2];
  logic        stall     [2];

  int n_assert = 0;
  int n_fail   = 0;

  // Reference memory contents, one image per instance
  logic [31:0] mm [2][256];

  dmem_responder #(.DEPTH_LOG2(8), .LATENCY(2)) dut_l2 (
    .clk(clk), .rst(rst[0]), .req_valid(req_valid[0]), .req_write(req_write[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_be(req_be[0]),
    .req_ready(req_ready[0]), .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]),
    .rsp_err(rsp_err[0]), .stall(stall[0])
  );

  dmem_responder #(.DEPTH_LOG2(8), .LATENCY(0)) dut_l0 (
    .clk(clk), .rst(rst[1]), .req_valid(req_valid[1]), .req_write(req_write[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_be(req_be[1]),
    .req_ready(req_ready[1]), .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]),
    .rsp_err(rsp_err[1]), .stall(stall[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int lat_of(input int d);
    return (d == 0) ? 2 : 0;
  endfunction

  function automatic bit exp_err(input logic [31:0] a);
    return (a % 4 != 0) || (a >= 32'd1024);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Entered just after a negedge. b2b: req_valid is already high from the
  // previous access, which is in its response cycle. keep: leave req_valid high.
  task automatic access(input int d, input bit w, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] be,
                        input bit b2b, input bit keep, input bit drop, input string tag);
    bit          err;
    logic [31:0] exp_rd;
    int          n;
    int          exp_n;
    bit          got;
    bit          vld;
    err    = exp_err(a);
    exp_rd = 32'h0;
    if (!err && !w) exp_rd = mm[d][a/4];
    req_valid[d] = 1'b1;
    req_write[d] = w;
    req_addr[d]  = a;
    req_wdata[d] = wd;
    req_be[d]    = be;
    #1;
    check({tag, ":ready_at_req"}, {31'b0, req_ready[d]}, b2b ? 32'd0 : 32'd1);
    exp_n = lat_of(d) + (b2b ? 2 : 1);
    vld = 1'b1; n = 0; got = 1'b0;
    while (!got && n < 40) begin
      @(posedge clk); @(negedge clk); n++;
      if (rsp_valid[d]) begin
        got = 1'b1;
      end else begin
        check({tag, ":stall_wait"}, {31'b0, stall[d]}, {31'b0, vld});
        if (!b2b) check({tag, ":ready_wait"}, {31'b0, req_ready[d]}, 32'd0);
        if (drop && !b2b && n == 1) begin
          // fields change after accept must not matter
          req_valid[d] = 1'b0;
          req_write[d] = ~w;
          req_addr[d]  = $urandom;
          req_wdata[d] = $urandom;
          req_be[d]    = 4'(~be);
          vld = 1'b0;
        end
      end
    end
    check({tag, ":latency"}, n, exp_n);
    if (got) begin
      check({tag, ":err"},   {31'b0, rsp_err[d]}, {31'b0, err});
      check({tag, ":rdata"}, rsp_rdata[d], exp_rd);
      check({tag, ":stall_rsp"}, {31'b0, stall[d]}, 32'd0);
      check({tag, ":ready_rsp"}, {31'b0, req_ready[d]}, 32'd0);
    end
    if (!err && w) begin
      for (int i = 0; i < 4; i++) if (be[i]) mm[d][a/4][8*i +: 8] = wd[8*i +: 8];
    end
    if (!keep) begin
      req_valid[d] = 1'b0;
      @(posedge clk); @(negedge clk);
      check({tag, ":post_valid"}, {31'b0, rsp_valid[d]}, 32'd0);
      check({tag, ":post_rdata"}, rsp_rdata[d], 32'd0);
      check({tag, ":post_err"},   {31'b0, rsp_err[d]}, 32'd0);
      check({tag, ":post_ready"}, {31'b0, req_ready[d]}, 32'd1);
    end
  endtask

  initial begin
    logic [31:0] a;
    int          d;
    int          r;
    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b1; req_valid[k] = 1'b0; req_write[k] = 1'b0;
      req_addr[k] = 32'h0; req_wdata[k] = 32'h0; req_be[k] = 4'h0;
    end

    // Reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check("rst:ready_in_rst", {31'b0, req_ready[k]}, 32'd0);
      check("rst:valid_in_rst", {31'b0, rsp_valid[k]}, 32'd0);
    end
    rst[0] = 1'b0; rst[1] = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      check("rst:ready", {31'b0, req_ready[k]}, 32'd1);
      check("rst:valid", {31'b0, rsp_valid[k]}, 32'd0);
      check("rst:rdata", rsp_rdata[k], 32'd0);
      check("rst:err",   {31'b0, rsp_err[k]}, 32'd0);
      check("rst:stall", {31'b0, stall[k]}, 32'd0);
    end
    @(negedge clk);

    // Full store then load, byte-enable merge
    access(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0, 1'b0, 1'b0, "st_full");
    access(0, 1'b0, 32'h10, 32'h0,        4'hF, 1'b0, 1'b0, 1'b0, "ld_full");
    access(0, 1'b1, 32'h10, 32'h000000AA, 4'h1, 1'b0, 1'b0, 1'b0, "st_byte");
    access(0, 1'b0, 32'h10, 32'h0,        4'h0, 1'b0, 1'b0, 1'b0, "ld_byte");

    // Errors: misaligned, out of range, aliasing store that must not land
    access(0, 1'b0, 32'h12,  32'h0,        4'hF, 1'b0, 1'b0, 1'b0, "ld_misal");
    access(0, 1'b0, 32'h400, 32'h0,        4'hF, 1'b0, 1'b0, 1'b0, "ld_range");
    access(0, 1'b1, 32'h410, 32'h55555555, 4'hF, 1'b0, 1'b0, 1'b0, "st_range");
    access(0, 1'b1, 32'h11,  32'h66666666, 4'hF, 1'b0, 1'b0, 1'b0, "st_misal");
    access(0, 1'b1, 32'h10,  32'h77777777, 4'h0, 1'b0, 1'b0, 1'b0, "st_be0");
    access(0, 1'b0, 32'h10,  32'h0,        4'hF, 1'b0, 1'b0, 1'b0, "ld_after_err");

    // Reset during WAIT on the edge that would perform the store
    access(0, 1'b1, 32'h20, 32'h0BADF00D, 4'hF, 1'b0, 1'b0, 1'b0, "st_pre");
    req_valid[0] = 1'b1; req_write[0] = 1'b1; req_addr[0] = 32'h20;
    req_wdata[0] = 32'h12345678; req_be[0] = 4'hF;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); @(negedge clk);
      check("abort:valid_wait", {31'b0, rsp_valid[0]}, 32'd0);
      check("abort:stall_wait", {31'b0, stall[0]}, 32'd1);
    end
    rst[0] = 1'b1; req_valid[0] = 1'b0;
    @(posedge clk); @(negedge clk);
    check("abort:valid_rst", {31'b0, rsp_valid[0]}, 32'd0);
    check("abort:ready_rst", {31'b0, req_ready[0]}, 32'd0);
    rst[0] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); @(negedge clk);
      check("abort:valid_after", {31'b0, rsp_valid[0]}, 32'd0);
      check("abort:ready_after", {31'b0, req_ready[0]}, 32'd1);
    end
    access(0, 1'b0, 32'h20, 32'h0, 4'hF, 1'b0, 1'b0, 1'b0, "ld_after_abort");

    // Zero latency, back-to-back with req_valid held
    access(1, 1'b1, 32'h40, 32'h11112222, 4'hF, 1'b0, 1'b0, 1'b0, "l0_st0");
    access(1, 1'b1, 32'h44, 32'h33334444, 4'hF, 1'b0, 1'b0, 1'b0, "l0_st1");
    access(1, 1'b0, 32'h40, 32'h0, 4'hF, 1'b0, 1'b1, 1'b0, "l0_b2b0");
    access(1, 1'b0, 32'h44, 32'h0, 4'hF, 1'b1, 1'b1, 1'b0, "l0_b2b1");
    access(1, 1'b1, 32'h40, 32'hCAFE0000, 4'hC, 1'b1, 1'b1, 1'b0, "l0_b2b2");
    access(1, 1'b0, 32'h40, 32'h0, 4'hF, 1'b1, 1'b1, 1'b0, "l0_b2b3");
    access(1, 1'b0, 32'h12, 32'h0, 4'hF, 1'b1, 1'b0, 1'b0, "l0_b2b_err");

    // Random: seed words 0..15 in both instances, then mixed traffic
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 16; i++) begin
        access(k, 1'b1, 32'(i * 4), $urandom, 4'hF, 1'b0, 1'b0, 1'b0, "rnd_seed");
      end
    end
    for (int i = 0; i < 80; i++) begin
      d = int'($urandom_range(0, 1));
      r = int'($urandom_range(0, 9));
      if (r == 0)      a = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(1, 3));
      else if (r == 1) a = ($urandom & 32'hFFFF_FFFC) | 32'h400;
      else             a = 32'($urandom_range(0, 15)) << 2;
      access(d, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)),
             1'b0, 1'b0, 1'($urandom_range(0, 1)), "rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
